ws2812b_stream: RTL and testbench

Parametrised next-generation WS2812-class LED strip driver with a pixel FIFO in front of the bit serialiser. Pixel width covers both RGB (24-bit) and RGBW (32-bit) strips. Bit timing is set in nanoseconds at elaboration. Consecutive pixels go out back-to-back with no inter-pixel gap, and a per-pixel latch flag requests the reset/latch low period. The block sits between the CPU peripheral register interface and the strip data pin.

---
 rtl/ws2812b_pkg.sv | 30 +++
 rtl/ws2812b_pixel_fifo.sv | 60 ++++++
 rtl/ws2812b_stream.sv | 170 +++++++++++++++++
 tb/tb_ws2812b_stream.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared types and elaboration-time helpers for the WS2812-class strip driver.
// Timing is converted from nanoseconds to clock cycles once, at elaboration.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } ser_state_t;

    // Round-to-nearest conversion; 64-bit math keeps long reset periods exact.
    function automatic longint unsigned cycles_from_ns(input longint unsigned clock_mhz,
                                                        input longint unsigned ns);
        return (clock_mhz * ns + 64'd500) / 64'd1000;
    endfunction

    function automatic bit timing_ok(input longint unsigned c0h,
                                     input longint unsigned c1h,
                                     input longint unsigned c_per,
                                     input longint unsigned c_res,
                                     input int              bpp);
        return (c0h > 0) && (c0h < c1h) && (c1h < c_per) && (c_res > 0) &&
               ((bpp == 24) || (bpp == 32));
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ws2812b_pixel_fifo.sv
// Pixel FIFO: each entry is {latch_flag, pixel}. Pushes while full and pops
// while empty are dropped so the level can never wrap.
module ws2812b_pixel_fifo
    import ws2812b_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("ws2812b_pixel_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ws2812b_stream.sv
// WS2812-class strip driver: pixel FIFO feeding a one-wire bit serialiser with
// back-to-back pixels, optional per-pixel latch period and sticky underrun.
module ws2812b_stream
    import ws2812b_pkg::*;
#(
    parameter int CLOCK_MHZ      = 64,
    parameter int BITS_PER_PIXEL = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int T0H_NS         = 400,
    parameter int T1H_NS         = 800,
    parameter int PERIOD_NS      = 1250,
    parameter int RES_NS         = 325000,
    parameter int INVERT         = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BITS_PER_PIXEL-1:0]         in_data,
    input  logic                              in_latch,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              busy,
    output logic                              underrun,
    input  logic                              underrun_clr,
    output logic                              led
);

    localparam longint unsigned C_PER_L = cycles_from_ns(64'(CLOCK_MHZ), 64'(PERIOD_NS));
    localparam longint unsigned C0H_L   = cycles_from_ns(64'(CLOCK_MHZ), 64'(T0H_NS));
    localparam longint unsigned C1H_L   = cycles_from_ns(64'(CLOCK_MHZ), 64'(T1H_NS));
    localparam longint unsigned C_RES_L = cycles_from_ns(64'(CLOCK_MHZ), 64'(RES_NS));

    localparam int C_PER   = int'(C_PER_L);
    localparam int C0H     = int'(C0H_L);
    localparam int C1H     = int'(C1H_L);
    localparam int C_RES   = int'(C_RES_L);
    localparam int CNT_MAX = (C_PER > C_RES) ? C_PER : C_RES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIDX_W  = $clog2(BITS_PER_PIXEL);
    localparam int FW      = BITS_PER_PIXEL + 1;
    localparam logic INV   = (INVERT != 0);

    if (!timing_ok(C0H_L, C1H_L, C_PER_L, C_RES_L, BITS_PER_PIXEL)) begin : g_bad_timing
        $error("ws2812b_stream: need 0 < C0H < C1H < C_PER, C_RES > 0, 24/32-bit pixels");
    end

    logic [FW-1:0]             fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      ready_en_q;

    ser_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BITS_PER_PIXEL-1:0] sh_q, sh_d;
    logic [BIDX_W-1:0]         bidx_q, bidx_d;
    logic                      flag_q, flag_d;
    logic                      led_q, led_d;
    logic                      underrun_q;
    logic                      set_underrun;
    logic                      load;
    logic [CNT_W-1:0]          high_thr;

    assign push     = in_valid && in_ready;
    assign in_ready = ready_en_q && !fifo_full;

    ws2812b_pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_latch, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        bidx_d       = bidx_q;
        flag_d       = flag_q;
        pop          = 1'b0;
        load         = 1'b0;
        set_underrun = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            BIT: begin
                if (cnt_q == CNT_W'(C_PER - 1)) begin
                    if (bidx_q != BIDX_W'(BITS_PER_PIXEL - 1)) begin
                        sh_d   = {sh_q[BITS_PER_PIXEL-2:0], 1'b0};
                        bidx_d = bidx_q + 1'b1;
                        cnt_d  = '0;
                    end else if (flag_q) begin
                        state_d = LATCH;
                        cnt_d   = '0;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        set_underrun = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(C_RES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop and start the first bit of the next pixel on the following cycle.
        if (load) begin
            pop     = 1'b1;
            state_d = BIT;
            cnt_d   = '0;
            sh_d    = fifo_rdata[BITS_PER_PIXEL-1:0];
            flag_d  = fifo_rdata[BITS_PER_PIXEL];
            bidx_d  = '0;
        end

        // led is computed from the next state so it lines up with the counter.
        high_thr = sh_d[BITS_PER_PIXEL-1] ? CNT_W'(C1H) : CNT_W'(C0H);
        led_d    = (state_d == BIT) && (cnt_d < high_thr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LATCH;
            cnt_q      <= '0;
            sh_q       <= '0;
            bidx_q     <= '0;
            flag_q     <= 1'b0;
            led_q      <= 1'b0;
            ready_en_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            bidx_q     <= bidx_d;
            flag_q     <= flag_d;
            led_q      <= led_d;
            ready_en_q <= 1'b1;
            if (set_underrun)      underrun_q <= 1'b1;
            else if (underrun_clr) underrun_q <= 1'b0;
        end
    end

    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;
    assign led      = led_q ^ INV;

endmodule

// File: tb/tb_ws2812b_stream.sv
// Randomised self-checking bench: a cycle-level waveform model built from the
// pixel/bit timing rules is compared against the strip pin.
module tb_ws2812b_stream;

    localparam int MHZ   = 64;
    localparam int PER_C = (MHZ * 1250 + 500) / 1000;
    localparam int T0H_C = (MHZ * 400 + 500) / 1000;
    localparam int T1H_C = (MHZ * 800 + 500) / 1000;
    localparam int RES_C = (MHZ * 2000 + 500) / 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst24 = 1'b1, rst32 = 1'b1;
    logic [23:0] d24 = '0;
    logic [31:0] d32 = '0;
    logic        lat24 = 0, lat32 = 0, v24 = 0, v32 = 0, clr24 = 0, clr32 = 0;
    logic        rdy24, rdy32, busy24, busy32, ur24, ur32, led24, led32;
    logic [2:0]  lvl24, lvl32;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_px[$];
    bit          mdl_lat[$];
    bit          exp_wave[$];
    bit          cap[$];

    ws2812b_stream #(.CLOCK_MHZ(MHZ), .BITS_PER_PIXEL(24), .FIFO_DEPTH(4), .RES_NS(2000), .INVERT(0)) dut24 (
        .clk(clk), .rst(rst24), .in_data(d24), .in_latch(lat24), .in_valid(v24), .in_ready(rdy24),
        .fifo_level(lvl24), .busy(busy24), .underrun(ur24), .underrun_clr(clr24), .led(led24));

    ws2812b_stream #(.CLOCK_MHZ(MHZ), .BITS_PER_PIXEL(32), .FIFO_DEPTH(4), .RES_NS(2000), .INVERT(1)) dut32 (
        .clk(clk), .rst(rst32), .in_data(d32), .in_latch(lat32), .in_valid(v32), .in_ready(rdy32),
        .fifo_level(lvl32), .busy(busy32), .underrun(ur32), .underrun_clr(clr32), .led(led32));

    function automatic bit pin(input bit sel);
        return sel ? led32 : led24;
    endfunction

    // Reference waveform: each bit is a fixed period with a data-dependent
    // high time; a latched pixel is followed by a low reset period.
    task automatic build_expected(input int bpp, input bit inv);
        exp_wave.delete();
        for (int p = 0; p < mdl_px.size(); p++) begin
            for (int b = bpp - 1; b >= 0; b--) begin
                int hi;
                hi = mdl_px[p][b] ? T1H_C : T0H_C;
                for (int c = 0; c < PER_C; c++) exp_wave.push_back((c < hi) ^ inv);
            end
            if (mdl_lat[p]) for (int c = 0; c < RES_C; c++) exp_wave.push_back(inv);
        end
    endtask

    task automatic push_px(input bit sel, input logic [31:0] d, input bit l);
        int k;
        k = 0;
        @(negedge clk);
        while (((sel ? rdy32 : rdy24) !== 1'b1) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300) begin
            errors++;
            $display("FAIL push_ready: in_ready=%0b after 300 cycles, required 1", sel ? rdy32 : rdy24);
            return;
        end
        if (sel) begin d32 = d; lat32 = l; v32 = 1'b1; end
        else     begin d24 = d[23:0]; lat24 = l; v24 = 1'b1; end
        @(negedge clk);
        v24 = 1'b0;
        v32 = 1'b0;
    endtask

    task automatic wait_start(input string name, input bit sel, input bit inv, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (pin(sel) !== inv) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_start: pin stayed %0b for 400 cycles, required a first bit", name, inv);
        end
    endtask

    task automatic run_compare(input string name, input bit sel, input bit inv);
        bit ok;
        int bad;
        bit bad_v;
        bad = -1;
        bad_v = 1'b0;
        cap.delete();
        wait_start(name, sel, inv, ok);
        if (!ok) return;
        for (int i = 0; i < exp_wave.size(); i++) begin
            if (i > 0) @(negedge clk);
            cap.push_back(pin(sel));
            if (pin(sel) !== exp_wave[i] && bad < 0) begin
                bad = i;
                bad_v = pin(sel);
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_wave: cycle %0d of %0d pin=%0b, required %0b",
                     name, bad, exp_wave.size(), bad_v, exp_wave[bad]);
        end
    endtask

    function automatic int count_level(input int from, input int len, input bit lv);
        int n;
        n = 0;
        for (int i = from; i < from + len && i < cap.size(); i++) if (cap[i] == lv) n++;
        return n;
    endfunction

    // Release rst24 at a falling edge and count edges until busy drops.
    task automatic release_and_count(input string name);
        int k;
        int hi;
        k = 0;
        hi = 0;
        @(negedge clk);
        rst24 = 1'b0;
        while (k < 1000) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                checks++;
                if (rdy24 !== 1'b1) begin errors++; $display("FAIL %s_ready: in_ready=%0b after first edge, required 1", name, rdy24); end
            end
            if (led24 !== 1'b0) hi++;
            if (busy24 !== 1'b1) break;
        end
        checks++;
        if (k != RES_C) begin errors++; $display("FAIL %s_latch_len: busy for %0d cycles, required %0d", name, k, RES_C); end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL %s_latch_quiet: pin high %0d cycles, required 0", name, hi); end
    endtask

    task automatic test_reset();
        rst24 = 1'b1;
        rst32 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rdy24 !== 1'b0)  begin errors++; $display("FAIL reset_ready: in_ready=%0b, required 0", rdy24); end
        checks++; if (lvl24 !== 3'd0)  begin errors++; $display("FAIL reset_level: fifo_level=%0d, required 0", lvl24); end
        checks++; if (busy24 !== 1'b1) begin errors++; $display("FAIL reset_busy: busy=%0b, required 1", busy24); end
        checks++; if (ur24 !== 1'b0)   begin errors++; $display("FAIL reset_underrun: underrun=%0b, required 0", ur24); end
        checks++; if (led24 !== 1'b0)  begin errors++; $display("FAIL reset_pin: led=%0b, required 0", led24); end
        checks++; if (led32 !== 1'b1)  begin errors++; $display("FAIL reset_pin_inv: led=%0b, required 1", led32); end
        rst32 = 1'b0;
        release_and_count("reset");
    endtask

    task automatic test_single_latch();
        mdl_px = '{32'h0080_0000};
        mdl_lat = '{1'b1};
        build_expected(24, 1'b0);
        fork
            push_px(1'b0, 32'h0080_0000, 1'b1);
            run_compare("single", 1'b0, 1'b0);
        join
        checks++;
        if (count_level(0, PER_C, 1'b1) != T1H_C) begin errors++; $display("FAIL single_bit0_high: %0d cycles, required %0d", count_level(0, PER_C, 1'b1), T1H_C); end
        checks++;
        if (count_level(PER_C, PER_C, 1'b1) != T0H_C) begin errors++; $display("FAIL single_bit1_high: %0d cycles, required %0d", count_level(PER_C, PER_C, 1'b1), T0H_C); end
        @(negedge clk);
        checks++;
        if (busy24 !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%0b after latch, required 0", busy24); end
    endtask

    task automatic test_back_to_back();
        mdl_px.delete();
        mdl_lat = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) mdl_px.push_back({8'h00, 24'($urandom)});
        build_expected(24, 1'b0);
        fork
            begin
                for (int i = 0; i < 3; i++) push_px(1'b0, mdl_px[i], mdl_lat[i]);
            end
            run_compare("b2b", 1'b0, 1'b0);
        join
        @(negedge clk);
        checks++;
        if (busy24 !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%0b, required 0", busy24); end
        checks++;
        if (ur24 !== 1'b0) begin errors++; $display("FAIL b2b_underrun: underrun=%0b, required 0", ur24); end
    endtask

    task automatic test_underrun();
        mdl_px = '{{8'h00, 24'($urandom)}};
        mdl_lat = '{1'b0};
        build_expected(24, 1'b0);
        fork
            push_px(1'b0, mdl_px[0], 1'b0);
            run_compare("underrun", 1'b0, 1'b0);
        join
        @(negedge clk);
        checks++;
        if (ur24 !== 1'b1) begin errors++; $display("FAIL underrun_set: underrun=%0b after last bit, required 1", ur24); end
        checks++;
        if (busy24 !== 1'b0) begin errors++; $display("FAIL underrun_idle: busy=%0b, required 0", busy24); end
        repeat (20) @(negedge clk);
        checks++;
        if (ur24 !== 1'b1) begin errors++; $display("FAIL underrun_sticky: underrun=%0b, required 1", ur24); end
        clr24 = 1'b1;
        @(negedge clk);
        clr24 = 1'b0;
        checks++;
        if (ur24 !== 1'b0) begin errors++; $display("FAIL underrun_clear: underrun=%0b, required 0", ur24); end
    endtask

    task automatic test_overflow();
        logic [31:0] px[6];
        int acc;
        int hi;
        acc = 0;
        hi = 0;
        rst24 = 1'b1;
        repeat (2) @(negedge clk);
        rst24 = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 6; i++) px[i] = {8'h00, 24'($urandom)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d24 = px[i][23:0];
            lat24 = (i >= 3);
            v24 = 1'b1;
            if (rdy24 === 1'b1) acc++;
        end
        @(negedge clk);
        v24 = 1'b0;
        checks++; if (acc != 4)      begin errors++; $display("FAIL ovf_accepts: %0d accepted, required 4", acc); end
        checks++; if (lvl24 !== 3'd4) begin errors++; $display("FAIL ovf_level: fifo_level=%0d, required 4", lvl24); end
        checks++; if (rdy24 !== 1'b0) begin errors++; $display("FAIL ovf_ready: in_ready=%0b when full, required 0", rdy24); end
        mdl_px = '{px[0], px[1], px[2], px[3]};
        mdl_lat = '{1'b0, 1'b0, 1'b0, 1'b1};
        build_expected(24, 1'b0);
        run_compare("ovf", 1'b0, 1'b0);
        repeat (200) begin
            @(negedge clk);
            if (led24 !== 1'b0) hi++;
        end
        checks++; if (hi != 0)        begin errors++; $display("FAIL ovf_dropped: pin high %0d cycles after frame, required 0", hi); end
        checks++; if (lvl24 !== 3'd0) begin errors++; $display("FAIL ovf_drain: fifo_level=%0d, required 0", lvl24); end
    endtask

    task automatic test_rgbw_invert();
        mdl_px = '{32'hFFFF_FFFF};
        mdl_lat = '{1'b1};
        build_expected(32, 1'b1);
        fork
            push_px(1'b1, 32'hFFFF_FFFF, 1'b1);
            run_compare("rgbw", 1'b1, 1'b1);
        join
        checks++;
        if (count_level(0, PER_C, 1'b0) != T1H_C) begin errors++; $display("FAIL rgbw_low: %0d cycles, required %0d", count_level(0, PER_C, 1'b0), T1H_C); end
        @(negedge clk);
        checks++;
        if (busy32 !== 1'b0 || led32 !== 1'b1) begin errors++; $display("FAIL rgbw_idle: busy=%0b pin=%0b, required 0/1", busy32, led32); end
    endtask

    task automatic test_reset_mid_bit();
        bit ok;
        mdl_px.delete();
        for (int i = 0; i < 2; i++) mdl_px.push_back({8'h00, 24'($urandom)});
        push_px(1'b0, mdl_px[0], 1'b0);
        push_px(1'b0, mdl_px[1], 1'b1);
        wait_start("midrst", 1'b0, 1'b0, ok);
        repeat (9 * PER_C + 40) @(negedge clk);
        checks++;
        if (lvl24 !== 3'd1) begin errors++; $display("FAIL midrst_queued: fifo_level=%0d before reset, required 1", lvl24); end
        #2 rst24 = 1'b1;
        #1;
        checks++; if (led24 !== 1'b0)  begin errors++; $display("FAIL midrst_pin: pin=%0b, required 0", led24); end
        checks++; if (lvl24 !== 3'd0)  begin errors++; $display("FAIL midrst_level: fifo_level=%0d, required 0", lvl24); end
        checks++; if (busy24 !== 1'b1) begin errors++; $display("FAIL midrst_busy: busy=%0b, required 1", busy24); end
        @(negedge clk);
        release_and_count("midrst");
        repeat (100) @(negedge clk);
        checks++;
        if (led24 !== 1'b0 || busy24 !== 1'b0) begin errors++; $display("FAIL midrst_discard: pin=%0b busy=%0b, required 0/0", led24, busy24); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_latch();
        test_back_to_back();
        test_underrun();
        test_overflow();
        test_rgbw_invert();
        test_reset_mid_bit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
